// File: rtl/bp_local_pkg.sv
// Shared types and encodings for the local-history branch predictor path.
package bp_local_pkg;

    localparam int HIST_BITS_DEF  = 10;
    // Tags carry a fixed-width index so the struct works for any HIST_BITS up to this width
    localparam int TAG_INDEX_BITS = 16;

    typedef logic [1:0] ctr2_t;

    localparam ctr2_t CTR_SNT = 2'b00;
    localparam ctr2_t CTR_WNT = 2'b01;
    localparam ctr2_t CTR_WT  = 2'b10;
    localparam ctr2_t CTR_ST  = 2'b11;

    typedef struct packed {
        logic                      valid;
        logic [TAG_INDEX_BITS-1:0] index;
        logic                      pred;
    } lpp_tag_t;

    typedef enum logic {
        LPP_INIT = 1'b0,
        LPP_RUN  = 1'b1
    } lpp_state_t;

endpackage

// File: rtl/sat_ctr2_update.sv
// Next value of a 2-bit saturating direction counter; shared with the tournament chooser.
module sat_ctr2_update
    import bp_local_pkg::*;
(
    input  ctr2_t ctr,
    input  logic  taken,
    output ctr2_t ctr_next
);

    // Step toward the resolved direction, holding at both ends
    always_comb begin
        ctr_next = ctr;
        case (ctr)
            CTR_SNT: ctr_next = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: ctr_next = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  ctr_next = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  ctr_next = taken ? CTR_ST  : CTR_WT;
            default: ctr_next = ctr;
        endcase
    end

endmodule

// File: rtl/local_pattern_predictor.sv
// Local-history pattern table: 2-bit counters indexed by per-branch history, trained at resolve.
// Optional statistics counters are enabled by defining LPP_STATS_EN.
module local_pattern_predictor
    import bp_local_pkg::*;
#(
    parameter int    HIST_BITS     = HIST_BITS_DEF,
    parameter int    RESOLVE_DELAY = 2,
    parameter ctr2_t INIT_CTR      = CTR_WNT
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 ready,
    input  logic                 lookup_valid,
    input  logic [HIST_BITS-1:0] lookup_hist,
    output logic                 pred_valid,
    output logic                 pred_taken,
    output logic                 pred_strong,
    input  logic                 resolve_valid,
    input  logic                 resolve_taken,
    output logic                 mispredict
`ifdef LPP_STATS_EN
    ,
    output logic [31:0]          stat_lookups,
    output logic [31:0]          stat_mispredicts
`endif
);

    localparam int                   DEPTH    = 1 << HIST_BITS;
    localparam logic [HIST_BITS-1:0] LAST_IDX = HIST_BITS'(DEPTH - 1);

    ctr2_t                ctr_mem_q [DEPTH];

    lpp_state_t           state_q, state_d;
    logic [HIST_BITS-1:0] init_ptr_q, init_ptr_d;
    logic                 ready_q, ready_d;
    logic                 pred_valid_q, pred_valid_d;
    logic                 pred_taken_q, pred_taken_d;
    logic                 pred_strong_q, pred_strong_d;
    logic                 mispredict_q, mispredict_d;
    lpp_tag_t             tag_q [RESOLVE_DELAY];
    lpp_tag_t             tag_d [RESOLVE_DELAY];

    lpp_tag_t             oldest_s;
    logic                 lookup_acc_s;
    logic                 upd_en_s;
    logic [HIST_BITS-1:0] upd_idx_s;
    ctr2_t                upd_cur_s;
    ctr2_t                upd_next_s;
    ctr2_t                lookup_ctr_s;
    logic                 mem_we_s;
    logic [HIST_BITS-1:0] mem_waddr_s;
    ctr2_t                mem_wdata_s;

    sat_ctr2_update u_upd (
        .ctr      (upd_cur_s),
        .taken    (resolve_taken),
        .ctr_next (upd_next_s)
    );

    // Pair the resolve with the oldest tag; forward a same-index update into the lookup read
    always_comb begin
        oldest_s     = tag_q[RESOLVE_DELAY-1];
        upd_idx_s    = oldest_s.index[HIST_BITS-1:0];
        upd_en_s     = (state_q == LPP_RUN) && resolve_valid && oldest_s.valid;
        upd_cur_s    = ctr_mem_q[upd_idx_s];
        lookup_acc_s = ready_q && lookup_valid;
        if (upd_en_s && (upd_idx_s == lookup_hist)) begin
            lookup_ctr_s = upd_next_s;
        end else begin
            lookup_ctr_s = ctr_mem_q[lookup_hist];
        end
    end

    // Single table write port: init sweep during INIT, training in RUN, nothing while in reset
    always_comb begin
        if (state_q == LPP_INIT) begin
            mem_we_s    = reset;
            mem_waddr_s = init_ptr_q;
            mem_wdata_s = INIT_CTR;
        end else begin
            mem_we_s    = reset && upd_en_s;
            mem_waddr_s = upd_idx_s;
            mem_wdata_s = upd_next_s;
        end
    end

    // Counter table storage
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            ctr_mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Next-state for the FSM, prediction outputs and tag pipeline
    always_comb begin
        state_d       = state_q;
        init_ptr_d    = init_ptr_q;
        ready_d       = ready_q;
        pred_valid_d  = lookup_acc_s;
        pred_taken_d  = pred_taken_q;
        pred_strong_d = pred_strong_q;
        mispredict_d  = 1'b0;

        case (state_q)
            LPP_INIT: begin
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == LAST_IDX) begin
                    state_d = LPP_RUN;
                    ready_d = 1'b1;
                end else begin
                    ready_d = 1'b0;
                end
            end
            LPP_RUN: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d    = LPP_INIT;
                init_ptr_d = '0;
                ready_d    = 1'b0;
            end
        endcase

        if (lookup_acc_s) begin
            pred_taken_d  = lookup_ctr_s[1];
            pred_strong_d = (lookup_ctr_s == CTR_SNT) || (lookup_ctr_s == CTR_ST);
        end else begin
            pred_taken_d  = pred_taken_q;
            pred_strong_d = pred_strong_q;
        end

        if (upd_en_s) begin
            mispredict_d = (resolve_taken != oldest_s.pred);
        end else begin
            mispredict_d = 1'b0;
        end

        tag_d[0] = '0;
        if (lookup_acc_s) begin
            tag_d[0].valid = 1'b1;
            tag_d[0].index = TAG_INDEX_BITS'(lookup_hist);
            tag_d[0].pred  = lookup_ctr_s[1];
        end else begin
            tag_d[0].valid = 1'b0;
        end
        for (int i = 1; i < RESOLVE_DELAY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Control and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= LPP_INIT;
            init_ptr_q    <= '0;
            ready_q       <= 1'b0;
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_strong_q <= 1'b0;
            mispredict_q  <= 1'b0;
            for (int i = 0; i < RESOLVE_DELAY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            init_ptr_q    <= init_ptr_d;
            ready_q       <= ready_d;
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            pred_strong_q <= pred_strong_d;
            mispredict_q  <= mispredict_d;
            for (int i = 0; i < RESOLVE_DELAY; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign ready       = ready_q;
    assign pred_valid  = pred_valid_q;
    assign pred_taken  = pred_taken_q;
    assign pred_strong = pred_strong_q;
    assign mispredict  = mispredict_q;

`ifdef LPP_STATS_EN
    logic [31:0] stat_lookups_q, stat_lookups_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    // Saturating event counters; mispredicts count alongside the mispredict output
    always_comb begin
        stat_lookups_d     = stat_lookups_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (lookup_acc_s && (stat_lookups_q != 32'hFFFF_FFFF)) begin
            stat_lookups_d = stat_lookups_q + 32'd1;
        end else begin
            stat_lookups_d = stat_lookups_q;
        end
        if (mispredict_d && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
            stat_mispredicts_d = stat_mispredicts_q + 32'd1;
        end else begin
            stat_mispredicts_d = stat_mispredicts_q;
        end
    end

    // Statistics registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            stat_lookups_q     <= 32'd0;
            stat_mispredicts_q <= 32'd0;
        end else begin
            stat_lookups_q     <= stat_lookups_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_lookups     = stat_lookups_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_local_pattern_predictor.sv
// Randomized and directed bench for local_pattern_predictor against a table/queue reference model.
module tb_local_pattern_predictor;

    localparam int HB    = 10;
    localparam int RD    = 2;
    localparam int DEPTH = 1 << HB;

    logic          clock = 1'b0;
    logic          reset;
    logic          ready;
    logic          lookup_valid;
    logic [HB-1:0] lookup_hist;
    logic          pred_valid;
    logic          pred_taken;
    logic          pred_strong;
    logic          resolve_valid;
    logic          resolve_taken;
    logic          mispredict;
`ifdef LPP_STATS_EN
    logic [31:0]   stat_lookups;
    logic [31:0]   stat_mispredicts;
`endif

    local_pattern_predictor #(
        .HIST_BITS     (HB),
        .RESOLVE_DELAY (RD),
        .INIT_CTR      (2'b01)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ready         (ready),
        .lookup_valid  (lookup_valid),
        .lookup_hist   (lookup_hist),
        .pred_valid    (pred_valid),
        .pred_taken    (pred_taken),
        .pred_strong   (pred_strong),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .mispredict    (mispredict)
`ifdef LPP_STATS_EN
        ,
        .stat_lookups     (stat_lookups),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: plain integer counters and a queue of outstanding lookups
    typedef struct {
        bit v;
        int idx;
        bit p;
    } pend_t;

    pend_t pend[$];
    int    mtab [DEPTH];
    bit    m_ready;
    int    m_init;
    bit    m_pt, m_ps;
    bit    e_pv, e_mis;
    int    m_lk, m_mc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit lv, input int h, input bit rv, input bit rt);
        pend_t o;
        pend_t n;
        int    c;
        e_pv  = 1'b0;
        e_mis = 1'b0;
        if (!rst) begin
            m_ready = 1'b0;
            m_init  = 0;
            m_pt    = 1'b0;
            m_ps    = 1'b0;
            m_lk    = 0;
            m_mc    = 0;
            pend.delete();
            for (int i = 0; i < RD; i++) begin
                n.v = 1'b0; n.idx = 0; n.p = 1'b0;
                pend.push_back(n);
            end
            return;
        end
        if (!m_ready) begin
            mtab[m_init] = 1;
            m_init++;
            if (m_init == DEPTH) m_ready = 1'b1;
            return;
        end
        o = pend.pop_front();
        if (rv && o.v) begin
            c = mtab[o.idx];
            mtab[o.idx] = rt ? ((c + 1 > 3) ? 3 : c + 1) : ((c - 1 < 0) ? 0 : c - 1);
            e_mis = (rt != o.p);
        end
        n.v = lv; n.idx = h; n.p = 1'b0;
        if (lv) begin
            c    = mtab[h];
            e_pv = 1'b1;
            m_pt = (c >= 2);
            m_ps = (c == 0) || (c == 3);
            n.p  = m_pt;
            m_lk++;
        end
        if (e_mis) m_mc++;
        pend.push_back(n);
    endtask

    task automatic step(input bit rst, input bit lv, input int h, input bit rv, input bit rt);
        bit chk_pt;
        reset         = rst;
        lookup_valid  = lv;
        lookup_hist   = HB'(h);
        resolve_valid = rv;
        resolve_taken = rt;
        model_step(rst, lv, h, rv, rt);
        chk_pt = e_pv || !rst;
        @(posedge clock);
        #1;
        check_eq("ready", ready, m_ready);
        check_eq("pred_valid", pred_valid, e_pv);
        check_eq("mispredict", mispredict, e_mis);
        if (chk_pt) begin
            check_eq("pred_taken", pred_taken, m_pt);
            check_eq("pred_strong", pred_strong, m_ps);
        end
`ifdef LPP_STATS_EN
        check_eq("stat_lookups", stat_lookups, m_lk);
        check_eq("stat_mispredicts", stat_mispredicts, m_mc);
`endif
    endtask

    task automatic wait_init(input string tag);
        int cnt;
        cnt = 0;
        while (ready !== 1'b1 && cnt < 2000) begin
            step(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cnt++;
        end
        check_eq(tag, cnt, 1024);
    endtask

    // Lookup h, one idle cycle, then resolve with direction rt; check prediction and mispredict
    task automatic train(input string tag, input int h, input bit rt,
                         input bit exp_pt, input bit exp_ps, input bit exp_mis);
        step(1'b1, 1'b1, h, 1'b0, 1'b0);
        check_eq({tag, "_pt"}, pred_taken, exp_pt);
        check_eq({tag, "_ps"}, pred_strong, exp_ps);
        step(1'b1, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 0, 1'b1, rt);
        check_eq({tag, "_mis"}, mispredict, exp_mis);
    endtask

    initial begin
        reset = 1'b0; lookup_valid = 1'b0; lookup_hist = '0;
        resolve_valid = 1'b0; resolve_taken = 1'b0;

        // Reset held for two cycles, then the init sweep
        step(1'b0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5, 1'b1, 1'b1);
        wait_init("init_len");
        step(1'b1, 1'b1, 0, 1'b0, 1'b0);
        check_eq("first_pt", pred_taken, 1'b0);
        check_eq("first_ps", pred_strong, 1'b0);

        // Saturating up-count on 0x2A5
        train("up0", 'h2A5, 1'b1, 1'b0, 1'b0, 1'b1);
        train("up1", 'h2A5, 1'b1, 1'b1, 1'b0, 1'b0);
        train("up2", 'h2A5, 1'b1, 1'b1, 1'b1, 1'b0);
        train("up3", 'h2A5, 1'b1, 1'b1, 1'b1, 1'b0);

        // Saturating down-count on 0x010
        train("dn0", 'h010, 1'b0, 1'b0, 1'b0, 1'b0);
        train("dn1", 'h010, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 'h010, 1'b0, 1'b0);
        check_eq("dn_sat_ps", pred_strong, 1'b1);

        // Same-cycle update and lookup of 0x155 forwards the new value
        step(1'b1, 1'b1, 'h155, 1'b0, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 'h155, 1'b1, 1'b1);
        check_eq("fwd_pt", pred_taken, 1'b1);
        check_eq("fwd_mis", mispredict, 1'b1);

        // Resolve with nothing outstanding
        step(1'b1, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 0, 1'b1, 1'b1);
        check_eq("orphan_mis", mispredict, 1'b0);
        step(1'b1, 1'b1, 'h0F0, 1'b0, 1'b0);
        check_eq("orphan_pt", pred_taken, 1'b0);

        // Random traffic over a small index set to provoke hazards
        for (int k = 0; k < 1500; k++) begin
            step(1'b1, 1'($urandom_range(0, 3) != 0), 37 * $urandom_range(0, 7),
                 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)));
        end

        // Reset with two lookups in flight
        step(1'b1, 1'b1, 'h2A5, 1'b0, 1'b0);
        step(1'b1, 1'b1, 'h155, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1, 1'b1);
        check_eq("rst_pv", pred_valid, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1, 1'b0);
        wait_init("reinit_len");

        // Every entry must read back weakly not-taken
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b1, i, 1'b0, 1'b0);
            check_eq("readback", {pred_taken, pred_strong}, 2'b00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
